// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    // Arbiter FSM states: idle, or holding an access for fetch or data.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    // Read data returned to the owner when the watchdog aborts an access.
    localparam logic [31:0] READ_ERR_DATA = 32'h0;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, memory and status signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: requests are levels held until the matching ready pulse.
//   slave  : arbiter view (takes requests, drives memory strobes and readies)
//   master : environment view (fetch unit, data controller and memory model)
interface mem_port_arbiter_if;
    // fetch side
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    // data side
    logic        d_read;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    // memory side
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_re;
    logic [3:0]  m_we;
    logic [31:0] m_rdata;
    logic        m_ready;
    // status
    logic        bus_err;
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_read, d_we, d_addr, d_wdata, m_rdata, m_ready,
        output i_rdata, i_ready, d_rdata, d_ready,
               m_addr, m_wdata, m_re, m_we, bus_err, busy
    );

    modport master (
        output i_req, i_addr, d_read, d_we, d_addr, d_wdata, m_rdata, m_ready,
        input  i_rdata, i_ready, d_rdata, d_ready,
               m_addr, m_wdata, m_re, m_we, bus_err, busy
    );
endinterface

// File: rtl/mem_port_arbiter_watchdog.sv
// Loadable down-counter that flags expiry when it has reached zero while enabled.
// Latency: expire_o is combinational from the count and en_i.
// Backpressure: none; load_i takes priority over counting.
//   clk, rst_n : clock and async active-low reset
//   load_i / load_val_i : preload the count
//   en_i : count down one per cycle; expire_o = en_i && count == 0
module arb_watchdog #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data; data wins, bounded by a burst limit.
// Latency: strobes one cycle after a request is seen in IDLE; ready is combinational on m_ready.
// Backpressure: requests are held levels; a new grant is only made from IDLE.
//   clock, reset_n : clock and async active-low reset
//   bus (slave)    : fetch/data request ports, memory port, bus_err and busy status
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 256,
    parameter int TO_W        = 9
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam logic [3:0]      BURST_MAX = 4'(MAX_D_BURST);
    // The watchdog fires when it has counted down to zero, i.e. on busy cycle TIMEOUT.
    localparam logic [TO_W-1:0] WD_LOAD   = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    arb_state_e  state_q;
    logic [31:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic        m_re_q;
    logic [3:0]  m_we_q;
    logic [3:0]  burst_q;

    logic d_req, d_is_wr, grant_d, grant_i, busy_w, wd_en, wd_expire, done;

    // A nonzero byte enable makes it a write; d_read is then ignored.
    assign d_is_wr = |bus.d_we;
    assign d_req   = bus.d_read | d_is_wr;

    assign grant_d = (state_q == IDLE) && d_req && (!bus.i_req || (burst_q < BURST_MAX));
    assign grant_i = (state_q == IDLE) && !grant_d && bus.i_req;

    assign busy_w  = (state_q != IDLE);
    assign wd_en   = busy_w && (TIMEOUT != 0);

    arb_watchdog #(.W(TO_W)) u_wd (
        .clk        (clock),
        .rst_n      (reset_n),
        .load_i     (grant_d | grant_i),
        .load_val_i (WD_LOAD),
        .en_i       (wd_en),
        .expire_o   (wd_expire)
    );

    // Memory completion beats a coincident watchdog expiry.
    assign done = busy_w && (bus.m_ready || wd_expire);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_re_q    <= 1'b0;
            m_we_q    <= '0;
            burst_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q   <= BUSY_D;
                        m_addr_q  <= bus.d_addr;
                        m_wdata_q <= bus.d_wdata;
                        m_re_q    <= !d_is_wr;
                        m_we_q    <= bus.d_we;
                        // Grant only happens below the limit, so +1 cannot exceed it.
                        burst_q   <= bus.i_req ? (burst_q + 4'd1) : 4'd0;
                    end else if (grant_i) begin
                        state_q   <= BUSY_I;
                        m_addr_q  <= bus.i_addr;
                        m_wdata_q <= '0;
                        m_re_q    <= 1'b1;
                        m_we_q    <= '0;
                        burst_q   <= '0;
                    end
                end
                default: begin
                    // Address and strobes are held; requester inputs are not looked at.
                    if (done) begin
                        state_q <= IDLE;
                        m_re_q  <= 1'b0;
                        m_we_q  <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_re    = m_re_q;
    assign bus.m_we    = m_we_q;
    assign bus.busy    = busy_w;

    assign bus.i_ready = (state_q == BUSY_I) && done;
    assign bus.d_ready = (state_q == BUSY_D) && done;
    assign bus.bus_err = busy_w && wd_expire && !bus.m_ready;

    // Read data is only passed through on a real memory completion.
    assign bus.i_rdata = (bus.i_ready && bus.m_ready) ? bus.m_rdata : READ_ERR_DATA;
    assign bus.d_rdata = (bus.d_ready && bus.m_ready) ? bus.m_rdata : READ_ERR_DATA;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus multi-cycle sequences.
// Latency: n/a.
// Backpressure: memory responses are driven directly by the bench.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_D_BURST(4), .TIMEOUT(8), .TO_W(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_read;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [31:0] m_rdata;
        logic        m_ready;
        logic        e_re;
        logic [3:0]  e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_iry;
        logic [31:0] e_irdata;
        logic        e_dry;
        logic [31:0] e_drdata;
        logic        e_err;
        logic        e_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic ir, input logic [31:0] ia, input logic dr, input logic [3:0] dw,
        input logic [31:0] da, input logic [31:0] dd, input logic [31:0] mr, input logic my,
        input logic ere, input logic [3:0] ewe, input logic [31:0] ea, input logic [31:0] ewd,
        input logic eiy, input logic [31:0] eid, input logic edy, input logic [31:0] edd,
        input logic eer, input logic ebs);
        vec_t v;
        v.i_req = ir;  v.i_addr = ia;  v.d_read = dr;  v.d_we = dw;
        v.d_addr = da; v.d_wdata = dd; v.m_rdata = mr; v.m_ready = my;
        v.e_re = ere;  v.e_we = ewe;   v.e_addr = ea;  v.e_wdata = ewd;
        v.e_iry = eiy; v.e_irdata = eid; v.e_dry = edy; v.e_drdata = edd;
        v.e_err = eer; v.e_busy = ebs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_req = 1'b0; bus.i_addr = '0; bus.d_read = 1'b0; bus.d_we = '0;
        bus.d_addr = '0;  bus.d_wdata = '0; bus.m_rdata = '0; bus.m_ready = 1'b0;
    endtask

    vec_t vt[$];
    int   n_dgr;
    bit   got_fetch;
    logic [3:0] burst_at_sat;
    int   pulse_cyc;

    initial begin
        drive_idle();
        // Rows: inputs (i_req,i_addr,d_read,d_we,d_addr,d_wdata,m_rdata,m_ready) then expected
        // (m_re,m_we,m_addr,m_wdata,i_ready,i_rdata,d_ready,d_rdata,bus_err,busy).
        // reset state
        vt.push_back(mk(0,0,0,0,0,0,0,0,                               0,0,0,0,0,0,0,0,0,0));
        // lone fetch, memory ready 3 cycles after m_re
        vt.push_back(mk(1,32'h1000,0,0,0,0,0,0,                        0,0,0,0,0,0,0,0,0,0));
        vt.push_back(mk(1,32'h1000,0,0,0,0,0,0,                        1,0,32'h1000,0,0,0,0,0,0,1));
        vt.push_back(mk(1,32'h1000,0,0,0,0,0,0,                        1,0,32'h1000,0,0,0,0,0,0,1));
        vt.push_back(mk(1,32'h1000,0,0,0,0,0,0,                        1,0,32'h1000,0,0,0,0,0,0,1));
        vt.push_back(mk(1,32'h1000,0,0,0,0,32'hCAFE_0001,1,            1,0,32'h1000,0,1,32'hCAFE_0001,0,0,0,1));
        // m_ready in IDLE is ignored
        vt.push_back(mk(0,0,0,0,0,0,32'hFFFF_FFFF,1,                   0,0,32'h1000,0,0,0,0,0,0,0));
        // simultaneous fetch and data read: data first, then fetch
        vt.push_back(mk(1,32'h2000,1,0,32'h8000_0010,0,0,0,            0,0,32'h1000,0,0,0,0,0,0,0));
        vt.push_back(mk(1,32'h2000,1,0,32'h8000_0010,0,0,0,            1,0,32'h8000_0010,0,0,0,0,0,0,1));
        vt.push_back(mk(1,32'h2000,1,0,32'h8000_0010,0,32'h1234_5678,1,1,0,32'h8000_0010,0,0,0,1,32'h1234_5678,0,1));
        vt.push_back(mk(1,32'h2000,0,0,0,0,0,0,                        0,0,32'h8000_0010,0,0,0,0,0,0,0));
        vt.push_back(mk(1,32'h2000,0,0,0,0,32'hAAAA_5555,1,            1,0,32'h2000,0,1,32'hAAAA_5555,0,0,0,1));
        vt.push_back(mk(0,0,0,0,0,0,0,0,                               0,0,32'h2000,0,0,0,0,0,0,0));
        // byte write with d_read also set: write wins
        vt.push_back(mk(0,0,1,4'b0100,32'h40,32'h00AB_0000,0,0,        0,0,32'h2000,0,0,0,0,0,0,0));
        vt.push_back(mk(0,0,1,4'b0100,32'h40,32'h00AB_0000,0,0,        0,4'b0100,32'h40,32'h00AB_0000,0,0,0,0,0,1));
        vt.push_back(mk(0,0,1,4'b0100,32'h40,32'h00AB_0000,0,0,        0,4'b0100,32'h40,32'h00AB_0000,0,0,0,0,0,1));
        vt.push_back(mk(0,0,1,4'b0100,32'h40,32'h00AB_0000,32'hDEAD,1, 0,4'b0100,32'h40,32'h00AB_0000,0,0,1,32'hDEAD,0,1));
        vt.push_back(mk(0,0,0,0,0,0,0,0,                               0,0,32'h40,32'h00AB_0000,0,0,0,0,0,0));

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;

        foreach (vt[r]) begin
            bus.i_req = vt[r].i_req;   bus.i_addr = vt[r].i_addr;
            bus.d_read = vt[r].d_read; bus.d_we = vt[r].d_we;
            bus.d_addr = vt[r].d_addr; bus.d_wdata = vt[r].d_wdata;
            bus.m_rdata = vt[r].m_rdata; bus.m_ready = vt[r].m_ready;
            @(negedge clock);
            chk($sformatf("row%0d m_re", r),    32'(bus.m_re),    32'(vt[r].e_re));
            chk($sformatf("row%0d m_we", r),    32'(bus.m_we),    32'(vt[r].e_we));
            chk($sformatf("row%0d m_addr", r),  bus.m_addr,       vt[r].e_addr);
            chk($sformatf("row%0d m_wdata", r), bus.m_wdata,      vt[r].e_wdata);
            chk($sformatf("row%0d i_ready", r), 32'(bus.i_ready), 32'(vt[r].e_iry));
            chk($sformatf("row%0d i_rdata", r), bus.i_rdata,      vt[r].e_irdata);
            chk($sformatf("row%0d d_ready", r), 32'(bus.d_ready), 32'(vt[r].e_dry));
            chk($sformatf("row%0d d_rdata", r), bus.d_rdata,      vt[r].e_drdata);
            chk($sformatf("row%0d bus_err", r), 32'(bus.bus_err), 32'(vt[r].e_err));
            chk($sformatf("row%0d busy", r),    32'(bus.busy),    32'(vt[r].e_busy));
            @(posedge clock); #1;
        end

        // Starvation: fetch held, data requests back to back -> 4 data grants, then fetch.
        drive_idle();
        bus.i_req = 1'b1;
        bus.i_addr = 32'h3000;
        n_dgr = 0;
        got_fetch = 1'b0;
        burst_at_sat = '0;
        for (int k = 0; k < 6 && !got_fetch; k++) begin
            bus.d_read = 1'b1;
            bus.d_addr = 32'h100 + 32'(k);
            bus.m_ready = 1'b0;
            @(posedge clock); #1;
            @(negedge clock);
            if (bus.m_re && bus.m_addr == 32'h3000) got_fetch = 1'b1;
            else if (bus.m_re && bus.m_addr == bus.d_addr) n_dgr++;
            if (n_dgr == 4 && !got_fetch) burst_at_sat = dut.burst_q;
            bus.m_ready = 1'b1;
            bus.m_rdata = 32'h5000 + 32'(k);
            #1;
            chk($sformatf("burst%0d i_ready", k), 32'(bus.i_ready), 32'(got_fetch));
            chk($sformatf("burst%0d d_ready", k), 32'(bus.d_ready), 32'(!got_fetch));
            @(posedge clock); #1;
            bus.m_ready = 1'b0;
            if (got_fetch) begin
                bus.i_req = 1'b0;
                bus.d_read = 1'b0;
            end
        end
        chk("burst data grants", 32'(n_dgr), 32'd4);
        chk("burst fetch granted", 32'(got_fetch), 32'd1);
        chk("burst saturated cnt", 32'(burst_at_sat), 32'd4);
        chk("burst cnt after fetch", 32'(dut.burst_q), 32'd0);

        // Timeout: memory never answers a data read.
        drive_idle();
        @(posedge clock); #1;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h50;
        @(posedge clock); #1;
        pulse_cyc = 0;
        for (int c = 1; c <= 12 && pulse_cyc == 0; c++) begin
            @(negedge clock);
            if (bus.d_ready) begin
                pulse_cyc = c;
                chk("timeout bus_err", 32'(bus.bus_err), 32'd1);
                chk("timeout d_rdata", bus.d_rdata, 32'd0);
                chk("timeout i_ready", 32'(bus.i_ready), 32'd0);
            end
            @(posedge clock); #1;
        end
        bus.d_read = 1'b0;
        chk("timeout busy cycle", 32'(pulse_cyc), 32'd8);
        @(negedge clock);
        chk("timeout m_re cleared", 32'(bus.m_re), 32'd0);
        chk("timeout idle", 32'(bus.busy), 32'd0);
        bus.m_ready = 1'b1;
        bus.m_rdata = 32'h7777_7777;
        #1;
        chk("late m_ready d_ready", 32'(bus.d_ready), 32'd0);
        chk("late m_ready d_rdata", bus.d_rdata, 32'd0);
        chk("late m_ready bus_err", 32'(bus.bus_err), 32'd0);
        @(posedge clock); #1;
        bus.m_ready = 1'b0;
        chk("late m_ready no grant", 32'(bus.busy), 32'd0);

        // Reset asserted while a fetch is in flight.
        drive_idle();
        bus.i_req = 1'b1;
        bus.i_addr = 32'h4000;
        @(posedge clock); #1;
        chk("rst pre m_re", 32'(bus.m_re), 32'd1);
        #2;
        reset_n = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        chk("rst m_re dropped", 32'(bus.m_re), 32'd0);
        chk("rst no i_ready", 32'(bus.i_ready), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        drive_idle();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst release idle", 32'(bus.busy), 32'd0);
        chk("rst release m_addr", bus.m_addr, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
